// File: rtl/mod_seq_pkg.sv
// Shared types and default widths for the modulation step sequencer.
package mod_seq_pkg;

  localparam int unsigned MOD_DEPTH = 8;
  localparam int unsigned MOD_PW    = 16;
  localparam int unsigned MOD_DW    = 16;

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    RUN
  } state_t;

  typedef struct packed {
    logic [MOD_PW-1:0] half_period;
    logic [MOD_DW-1:0] dwell;
    logic              last;
  } mod_step_t;

endpackage

// File: rtl/mod_seq_table.sv
// Step table: one write port and one registered read port, contents are not reset.
module mod_seq_table
  import mod_seq_pkg::*;
#(
  parameter int unsigned DEPTH   = MOD_DEPTH,
  parameter type         entry_t = mod_step_t,
  parameter int unsigned AW      = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  entry_t        wr_data,
  input  logic [AW-1:0] rd_addr,
  output entry_t        rd_data
);

  entry_t mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
    rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/mod_sequencer.sv
// Plays a table of modulation steps onto the modulator enable/half-period inputs,
// advancing on counted rising edges of the carrier sync strobe.
module mod_sequencer
  import mod_seq_pkg::*;
#(
  parameter int unsigned DEPTH = MOD_DEPTH,
  parameter int unsigned PW    = MOD_PW,
  parameter int unsigned DW    = MOD_DW,
  localparam int unsigned AW   = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          sync,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [PW-1:0] wr_half_period,
  input  logic [DW-1:0] wr_dwell,
  input  logic          wr_last,
  input  logic          start,
  input  logic          stop,
  input  logic          loop,
  output logic          mod_enable,
  output logic [PW-1:0] mod_half_period,
  output logic          busy,
  output logic [AW-1:0] step_idx,
  output logic          done
);

  typedef struct packed {
    logic [PW-1:0] half_period;
    logic [DW-1:0] dwell;
    logic          last;
  } step_t;

  state_t        state_q, state_d;
  logic          sync_q;
  logic [AW-1:0] idx_q, idx_d;
  logic [DW-1:0] cnt_q, cnt_d;
  logic [DW-1:0] curDwell_q, curDwell_d;
  logic          curLast_q, curLast_d;
  logic [PW-1:0] halfPeriod_q, halfPeriod_d;
  logic          enable_q, enable_d;
  logic          busy_q, busy_d;
  logic [AW-1:0] stepIdx_q, stepIdx_d;
  logic          done_q, done_d;

  step_t         wrEntry;
  step_t         rdEntry;
  logic          syncRise;
  logic [DW-1:0] dwellEff;
  logic [DW-1:0] cntInc;
  logic          stepEnd;
  logic          isLast;

  assign wrEntry = '{half_period: wr_half_period, dwell: wr_dwell, last: wr_last};

  // Read address follows the next index so the entry is ready during FETCH.
  mod_seq_table #(
    .DEPTH  (DEPTH),
    .entry_t(step_t)
  ) u_table (
    .clk    (clk),
    .wr_en  (wr_en),
    .wr_addr(wr_addr),
    .wr_data(wrEntry),
    .rd_addr(idx_d),
    .rd_data(rdEntry)
  );

  assign syncRise = sync & ~sync_q;
  assign dwellEff = (curDwell_q == '0) ? DW'(1) : curDwell_q;
  assign cntInc   = cnt_q + DW'(1);
  // First term covers a sync edge caught during FETCH on a one-edge step.
  assign stepEnd  = (cnt_q == dwellEff) || (syncRise && (cntInc == dwellEff));
  assign isLast   = curLast_q || (stepIdx_q == AW'(DEPTH - 1));

  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    cnt_d        = cnt_q;
    curDwell_d   = curDwell_q;
    curLast_d    = curLast_q;
    halfPeriod_d = halfPeriod_q;
    enable_d     = enable_q;
    busy_d       = busy_q;
    stepIdx_d    = stepIdx_q;
    done_d       = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = FETCH;
          idx_d   = '0;
          busy_d  = 1'b1;
        end
      end
      FETCH: begin
        state_d      = RUN;
        cnt_d        = syncRise ? DW'(1) : '0;
        halfPeriod_d = rdEntry.half_period;
        enable_d     = |rdEntry.half_period;
        curDwell_d   = rdEntry.dwell;
        curLast_d    = rdEntry.last;
        stepIdx_d    = idx_q;
      end
      RUN: begin
        if (syncRise) begin
          cnt_d = cntInc;
        end
        if (stepEnd) begin
          if (!isLast) begin
            state_d = FETCH;
            idx_d   = idx_q + AW'(1);
          end else if (loop) begin
            state_d = FETCH;
            idx_d   = '0;
          end else begin
            state_d  = IDLE;
            busy_d   = 1'b0;
            enable_d = 1'b0;
            done_d   = 1'b1;
          end
        end
      end
      default: begin
        state_d  = IDLE;
        busy_d   = 1'b0;
        enable_d = 1'b0;
      end
    endcase

    if (stop) begin
      state_d  = IDLE;
      idx_d    = idx_q;
      busy_d   = 1'b0;
      enable_d = 1'b0;
      done_d   = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      sync_q       <= 1'b0;
      idx_q        <= '0;
      cnt_q        <= '0;
      curDwell_q   <= '0;
      curLast_q    <= 1'b0;
      halfPeriod_q <= '0;
      enable_q     <= 1'b0;
      busy_q       <= 1'b0;
      stepIdx_q    <= '0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      sync_q       <= sync;
      idx_q        <= idx_d;
      cnt_q        <= cnt_d;
      curDwell_q   <= curDwell_d;
      curLast_q    <= curLast_d;
      halfPeriod_q <= halfPeriod_d;
      enable_q     <= enable_d;
      busy_q       <= busy_d;
      stepIdx_q    <= stepIdx_d;
      done_q       <= done_d;
    end
  end

  assign mod_enable      = enable_q;
  assign mod_half_period = halfPeriod_q;
  assign busy            = busy_q;
  assign step_idx        = stepIdx_q;
  assign done            = done_q;

endmodule

// File: tb/tb_mod_sequencer.sv
// Directed self-checking bench for mod_sequencer with hand-computed expectations.
module tb_mod_sequencer;

  localparam int unsigned DEPTH = 8;
  localparam int unsigned PW    = 16;
  localparam int unsigned DW    = 16;
  localparam int unsigned AW    = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic          sync;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [PW-1:0] wr_half_period;
  logic [DW-1:0] wr_dwell;
  logic          wr_last;
  logic          start;
  logic          stop;
  logic          loop;
  logic          mod_enable;
  logic [PW-1:0] mod_half_period;
  logic          busy;
  logic [AW-1:0] step_idx;
  logic          done;

  int checkCount = 0;
  int passCount  = 0;
  int doneCount  = 0;
  int doneBase;

  mod_sequencer #(
    .DEPTH(DEPTH),
    .PW   (PW),
    .DW   (DW)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .sync           (sync),
    .wr_en          (wr_en),
    .wr_addr        (wr_addr),
    .wr_half_period (wr_half_period),
    .wr_dwell       (wr_dwell),
    .wr_last        (wr_last),
    .start          (start),
    .stop           (stop),
    .loop           (loop),
    .mod_enable     (mod_enable),
    .mod_half_period(mod_half_period),
    .busy           (busy),
    .step_idx       (step_idx),
    .done           (done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (done) doneCount <= doneCount + 1;
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checkCount++;
    if (observed === expected) begin
      passCount++;
    end else begin
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Hold start/stop/sync for exactly one clock edge, then release start/stop.
  task automatic applyStimulus(input logic startV, input logic stopV, input logic syncV);
    start = startV;
    stop  = stopV;
    sync  = syncV;
    tick();
    start = 1'b0;
    stop  = 1'b0;
  endtask

  // One multi-cycle sync pulse; new step outputs are visible when this returns.
  task automatic syncEdge();
    applyStimulus(1'b0, 1'b0, 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0);
  endtask

  task automatic writeEntry(input int addr, input int hp, input int dw, input logic last);
    wr_en          = 1'b1;
    wr_addr        = AW'(addr);
    wr_half_period = PW'(hp);
    wr_dwell       = DW'(dw);
    wr_last        = last;
    tick();
    wr_en = 1'b0;
  endtask

  task automatic checkStep(input string tag, input int idx, input int hp);
    checkOutput({tag, " idx"}, 32'(step_idx), 32'(idx));
    checkOutput({tag, " hp"}, 32'(mod_half_period), 32'(hp));
    checkOutput({tag, " en"}, 32'(mod_enable), 32'(hp != 0));
  endtask

  task automatic loadBaseProgram();
    writeEntry(0, 100, 2, 1'b0);
    writeEntry(1, 0, 1, 1'b0);
    writeEntry(2, 250, 3, 1'b1);
  endtask

  initial begin
    rst = 1'b1; sync = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_half_period = '0;
    wr_dwell = '0; wr_last = 1'b0; start = 1'b0; stop = 1'b0; loop = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    tick();
    checkOutput("reset en", 32'(mod_enable), 0);
    checkOutput("reset hp", 32'(mod_half_period), 0);
    checkOutput("reset busy", 32'(busy), 0);
    checkOutput("reset done", 32'(done), 0);
    checkOutput("reset idx", 32'(step_idx), 0);

    // Basic one-shot program.
    loadBaseProgram();
    doneBase = doneCount;
    applyStimulus(1'b1, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0);
    checkOutput("run busy", 32'(busy), 1);
    checkStep("s0", 0, 100);
    syncEdge();
    checkStep("s0 hold", 0, 100);
    syncEdge();
    checkStep("s1", 1, 0);
    syncEdge();
    checkStep("s2", 2, 250);
    syncEdge();
    syncEdge();
    checkStep("s2 hold", 2, 250);
    applyStimulus(1'b0, 1'b0, 1'b1);
    checkOutput("end done", 32'(done), 1);
    checkOutput("end busy", 32'(busy), 0);
    checkOutput("end en", 32'(mod_enable), 0);
    applyStimulus(1'b0, 1'b0, 1'b1);
    checkOutput("done pulse width", 32'(done), 0);
    applyStimulus(1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0);
    checkOutput("one-shot done count", 32'(doneCount - doneBase), 1);

    // Looping program, three full passes, plus start-while-busy.
    loop = 1'b1;
    doneBase = doneCount;
    applyStimulus(1'b1, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0);
    for (int p = 0; p < 3; p++) begin
      syncEdge();
      syncEdge();
      checkStep("loop s1", 1, 0);
      if (p == 0) begin
        applyStimulus(1'b1, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0);
        checkStep("start ignored", 1, 0);
      end
      syncEdge();
      checkStep("loop s2", 2, 250);
      syncEdge();
      syncEdge();
      syncEdge();
      checkStep("loop s0", 0, 100);
      checkOutput("loop busy", 32'(busy), 1);
    end
    checkOutput("loop no done", 32'(doneCount - doneBase), 0);
    applyStimulus(1'b0, 1'b1, 1'b0);
    checkOutput("stop en", 32'(mod_enable), 0);
    checkOutput("stop busy", 32'(busy), 0);

    // Rewrite entry 0 while it plays.
    applyStimulus(1'b1, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0);
    checkStep("rw s0", 0, 100);
    writeEntry(0, 500, 1, 1'b0);
    checkStep("rw s0 kept", 0, 100);
    syncEdge();
    checkStep("rw s0 kept2", 0, 100);
    syncEdge();
    checkStep("rw s1", 1, 0);
    syncEdge();
    syncEdge();
    syncEdge();
    syncEdge();
    checkStep("rw new s0", 0, 500);
    syncEdge();
    checkStep("rw s1 again", 1, 0);
    applyStimulus(1'b0, 1'b1, 1'b0);

    // Stop and start together mid entry 1.
    loop = 1'b0;
    writeEntry(0, 100, 2, 1'b0);
    doneBase = doneCount;
    applyStimulus(1'b1, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0);
    syncEdge();
    syncEdge();
    checkStep("pre-stop s1", 1, 0);
    applyStimulus(1'b1, 1'b1, 1'b0);
    checkOutput("stop+start busy", 32'(busy), 0);
    checkOutput("stop+start en", 32'(mod_enable), 0);
    applyStimulus(1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0);
    checkOutput("start was ignored", 32'(busy), 0);
    syncEdge();
    checkOutput("stop no done", 32'(doneCount - doneBase), 0);

    // Dwell 0 acts as a single edge.
    writeEntry(0, 40, 0, 1'b1);
    applyStimulus(1'b1, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0);
    checkStep("dw0", 0, 40);
    applyStimulus(1'b0, 1'b0, 1'b1);
    checkOutput("dw0 done", 32'(done), 1);
    applyStimulus(1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0);

    // Full table with no last flag ends after entry 7.
    for (int i = 0; i < 8; i++) writeEntry(i, 10 + i, 1, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0);
    checkStep("full s0", 0, 10);
    for (int i = 1; i < 8; i++) begin
      syncEdge();
      checkStep("full step", i, 10 + i);
    end
    applyStimulus(1'b0, 1'b0, 1'b1);
    checkOutput("full done", 32'(done), 1);
    checkOutput("full busy", 32'(busy), 0);
    applyStimulus(1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0);

    // Async reset mid-run, then a held-high sync must wait for its next rise.
    loop = 1'b1;
    applyStimulus(1'b1, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0);
    begin
      int n;
      n = $urandom_range(0, 3);
      for (int k = 0; k < n; k++) syncEdge();
      checkOutput("pre-rst busy", 32'(busy), 1);
    end
    #3;
    rst  = 1'b1;
    sync = 1'b1;
    #1;
    checkOutput("async rst en", 32'(mod_enable), 0);
    checkOutput("async rst hp", 32'(mod_half_period), 0);
    checkOutput("async rst busy", 32'(busy), 0);
    checkOutput("async rst idx", 32'(step_idx), 0);
    #1;
    rst = 1'b0;
    tick();
    checkOutput("post-rst idle", 32'(busy), 0);
    applyStimulus(1'b1, 1'b0, 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b1);
    checkStep("post-rst s0", 0, 10);
    applyStimulus(1'b0, 1'b0, 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b1);
    checkStep("held sync ignored", 0, 10);
    applyStimulus(1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0);
    syncEdge();
    checkStep("post-rst s1", 1, 11);
    applyStimulus(1'b0, 1'b1, 1'b0);
    checkOutput("final stop busy", 32'(busy), 0);

    $display("[TB] %0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
